// File: rtl/sync_evt_pkg.sv
// Shared types and helpers for the synchronized event window counter.
// Holds the FSM state encoding, the window-select width and the window
// length helper used by the top when arming or re-arming a window.
package sync_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIN_SEL_W = 3;

  // Window length in clk cycles: base length scaled by a power of two
  function automatic int win_len(input int base, input logic [WIN_SEL_W-1:0] sel);
    return base << sel;
  endfunction

endpackage

// File: rtl/sync_evt_edge_det.sv
// Registered rising-edge detector for a signal already in the clk domain.
// The history flop resets to 0. A second flop marks whether that history
// is real: in the first cycle after reset there is no previous sample, so
// no edge is reported. This keeps a level that is held high across reset
// from being mistaken for a fresh edge.
module sync_evt_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;
  logic primed;

  // Capture the previous sample and note when that sample is meaningful
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      primed <= 1'b0;
    end else begin
      q      <= d;
      primed <= 1'b1;
    end
  end

  assign rise = d & ~q & primed;

endmodule

// File: rtl/sync_evt_window_counter.sv
// Counts rising edges of a synchronized event level inside a window armed
// by a rising edge of trg, and presents the count on a valid/ready port.
// Optional feature macro: SYNC_EVT_RESTART_EN -- when defined, a trg edge
// during COUNT restarts the window; otherwise it is ignored.
module sync_evt_window_counter
  import sync_evt_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int BASE_WIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_in,
  input  logic                 trg,
  input  logic                 ena_blk,
  input  logic [WIN_SEL_W-1:0] win_sel,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 cnt_valid,
  input  logic                 cnt_ready,
  output logic                 busy,
  output logic                 ovf_o
);

  localparam int WIN_W = $clog2(BASE_WIN << 7);
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             ev_rise;
  logic             trg_rise;
  logic             ev_hit;

  sync_evt_edge_det u_ev_det (
    .clk  (clk),
    .rst  (rst),
    .d    (ev_in),
    .rise (ev_rise)
  );

  sync_evt_edge_det u_trg_det (
    .clk  (clk),
    .rst  (rst),
    .d    (trg),
    .rise (trg_rise)
  );

  assign win_load = WIN_W'(win_len(BASE_WIN, win_sel) - 1);

  // Next accumulator value including this cycle's event, saturating at max
  always_comb begin
    ev_hit  = ena_blk & ev_rise;
    acc_nxt = acc;
    ovf_nxt = ovf;
    if (ev_hit) begin
      if (acc == ACC_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        acc_nxt = acc + 1'b1;
      end
    end
  end

  // Window FSM with registered result, valid and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt_o     <= '0;
      ovf_o     <= 1'b0;
      cnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trg_rise) begin
            win_cnt <= win_load;
            acc     <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= COUNT;
          end
        end
        COUNT: begin
`ifdef SYNC_EVT_RESTART_EN
          if (trg_rise) begin
            win_cnt <= win_load;
            acc     <= '0;
            ovf     <= 1'b0;
          end else
`endif
          if (win_cnt == '0) begin
            cnt_o     <= acc_nxt;
            ovf_o     <= ovf_nxt;
            cnt_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc     <= acc_nxt;
            ovf     <= ovf_nxt;
            win_cnt <= win_cnt - 1'b1;
          end
        end
        DONE: begin
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_evt_window_counter.sv
// Testbench for sync_evt_window_counter (CNT_W=8, BASE_WIN=4).
// Honours SYNC_EVT_RESTART_EN in its reference model when defined.
module tb_sync_evt_window_counter;

  localparam int CNT_W    = 8;
  localparam int BASE_WIN = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int LOG_N    = 8192;
`ifdef SYNC_EVT_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             ev_in;
  logic             trg;
  logic             ena_blk;
  logic [2:0]       win_sel;
  logic [CNT_W-1:0] cnt_o;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             busy;
  logic             ovf_o;

  sync_evt_window_counter #(.CNT_W(CNT_W), .BASE_WIN(BASE_WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_in     (ev_in),
    .trg       (trg),
    .ena_blk   (ena_blk),
    .win_sel   (win_sel),
    .cnt_o     (cnt_o),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .busy      (busy),
    .ovf_o     (ovf_o)
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_pass;

  // Reference model: mode 0 idle, 1 window open, 2 result held
  int m_mode;
  int m_start;
  int m_len;
  int m_cnt;
  bit m_ovf;
  bit hist_ok;
  bit prev_ev;
  bit prev_trg;
  int cyc;
  bit rise_log[LOG_N];
  bit ena_log[LOG_N];

  typedef struct {
    bit       rst;
    bit       trg;
    bit       ev;
    bit       ena;
    bit [2:0] sel;
    bit       rdy;
    bit       v;
    bit       b;
    int       cnt;
    bit       ovf;
  } vec_t;

  vec_t tbl[14];

  task automatic checkVal(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - 1);
  endtask

  // Count qualified event edges in cycles (start, stop] from the logs
  function automatic int windowEvents(input int start, input int stop);
    int n = 0;
    for (int k = start + 1; k <= stop; k++) begin
      if (k < LOG_N && rise_log[k] && ena_log[k]) n++;
    end
    return n;
  endfunction

  task automatic modelStep(input bit r, input bit t, input bit e, input bit en,
                           input bit [2:0] s, input bit rd);
    bit evr;
    bit tr;
    int n;
    evr = hist_ok && e && !prev_ev;
    tr  = hist_ok && t && !prev_trg;
    if (cyc < LOG_N) begin
      rise_log[cyc] = evr;
      ena_log[cyc]  = en;
    end
    if (r) begin
      m_mode  = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      hist_ok = 1'b0;
    end else begin
      hist_ok = 1'b1;
      case (m_mode)
        0: if (tr) begin
          m_start = cyc;
          m_len   = BASE_WIN << s;
          m_mode  = 1;
        end
        1: if (RESTART && tr) begin
          m_start = cyc;
          m_len   = BASE_WIN << s;
        end else if (cyc == m_start + m_len) begin
          n      = windowEvents(m_start, cyc);
          m_cnt  = (n > CNT_MAX) ? CNT_MAX : n;
          m_ovf  = (n > CNT_MAX);
          m_mode = 2;
        end
        default: if (rd) m_mode = 0;
      endcase
    end
    prev_ev  = e;
    prev_trg = t;
    cyc++;
  endtask

  task automatic checkOutput();
    checkVal("model_valid", int'(cnt_valid), int'(m_mode == 2));
    checkVal("model_busy", int'(busy), int'(m_mode != 0));
    checkVal("model_cnt", int'(cnt_o), m_cnt);
    checkVal("model_ovf", int'(ovf_o), int'(m_ovf));
  endtask

  // One clk cycle: drive at negedge, model at posedge, check at next negedge
  task automatic applyStimulus(input bit r, input bit t, input bit e, input bit en,
                               input bit [2:0] s, input bit rd);
    rst       = r;
    trg       = t;
    ev_in     = e;
    ena_blk   = en;
    win_sel   = s;
    cnt_ready = rd;
    @(posedge clk);
    modelStep(r, t, e, en, s, rd);
    @(negedge clk);
    checkOutput();
  endtask

  // Directed tables, multi-cycle corner sequences, then randomized traffic
  initial begin
    int vexp;
    checks_total = 0;
    checks_pass  = 0;
    m_mode = 0; m_start = 0; m_len = 0; m_cnt = 0; m_ovf = 1'b0;
    hist_ok = 1'b0; prev_ev = 1'b0; prev_trg = 1'b0; cyc = 0;
    rst = 1'b1; trg = 1'b0; ev_in = 1'b0; ena_blk = 1'b0; win_sel = '0; cnt_ready = 1'b0;

    //          rst trg ev ena sel rdy  v  b cnt ovf
    tbl[0]  = '{1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 1, 3'd0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 3'd0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 3'd0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 3'd0, 0, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 3'd0, 0, 1, 1, 2, 0};
    tbl[11] = '{0, 0, 0, 1, 3'd0, 0, 1, 1, 2, 0};
    tbl[12] = '{0, 0, 1, 1, 3'd0, 1, 0, 0, 2, 0};
    tbl[13] = '{0, 0, 0, 1, 3'd0, 0, 0, 0, 2, 0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].trg, tbl[i].ev, tbl[i].ena, tbl[i].sel, tbl[i].rdy);
      checkVal("tbl_valid", int'(cnt_valid), int'(tbl[i].v));
      checkVal("tbl_busy", int'(busy), int'(tbl[i].b));
      checkVal("tbl_cnt", int'(cnt_o), tbl[i].cnt);
      checkVal("tbl_ovf", int'(ovf_o), int'(tbl[i].ovf));
    end

    $display("[TB] gate sequence, W=8");
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(1'b0, c == 0, (c % 2 == 1) && (c < 8), !(c == 3 || c == 5), 3'd1, c >= 9);
      checkVal("gate_busy", int'(busy), int'(c <= 8));
      if (c == 8) begin
        checkVal("gate_valid", int'(cnt_valid), 1);
        checkVal("gate_cnt", int'(cnt_o), 2);
      end
    end

    $display("[TB] saturation sequence, W=512");
    for (int c = 0; c <= 514; c++) begin
      applyStimulus(1'b0, c == 0, (c % 2 == 1) && (c <= 512), 1'b1, 3'd7, c == 513);
      if (c == 512) begin
        checkVal("sat_valid", int'(cnt_valid), 1);
        checkVal("sat_cnt", int'(cnt_o), CNT_MAX);
        checkVal("sat_ovf", int'(ovf_o), 1);
      end
    end

    $display("[TB] backpressure sequence, W=4");
    for (int c = 0; c <= 17; c++) begin
      applyStimulus(1'b0, c == 0 || c == 7 || c == 10, c == 2, 1'b1, 3'd0, c == 15);
      if (c >= 4 && c <= 14) begin
        checkVal("bp_valid", int'(cnt_valid), 1);
        checkVal("bp_cnt", int'(cnt_o), 1);
        checkVal("bp_busy", int'(busy), 1);
      end
      if (c >= 15) checkVal("bp_idle", int'(busy), 0);
    end

    $display("[TB] mid-window retrigger, W=16");
    vexp = RESTART ? 20 : 17;
    for (int c = 0; c <= 23; c++) begin
      applyStimulus(1'b0, c == 0 || c == 3, (c % 2 == 1) && (c <= 12), 1'b1, 3'd2, c == 22);
      checkVal("mid_valid", int'(cnt_valid), int'(c >= vexp - 1 && c < 22));
      if (c == vexp - 1) checkVal("mid_cnt", int'(cnt_o), RESTART ? 4 : 6);
    end

    $display("[TB] reset mid-window");
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(c == 5, c == 0, c % 2 == 1, 1'b1, 3'd2, 1'b0);
      if (c == 5) begin
        checkVal("rstmid_valid", int'(cnt_valid), 0);
        checkVal("rstmid_cnt", int'(cnt_o), 0);
        checkVal("rstmid_ovf", int'(ovf_o), 0);
      end
      if (c >= 5) checkVal("rstmid_busy", int'(busy), 0);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 599) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) != 0,
                    3'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
